// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock show-ahead FIFO with full/empty/almost flags.       |
// | Optional FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.           |
// | Revision  : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH            = 8,
  parameter int ALMOST_FULL_THR  = 2,
  parameter int ALMOST_EMPTY_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_ptr_w  = c_addr_w + 1;

  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0] c_af_level  = c_ptr_w'(DEPTH - ALMOST_FULL_THR);
  localparam logic [c_ptr_w-1:0] c_ae_level  = c_ptr_w'(ALMOST_EMPTY_THR);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wptr;
  logic [c_ptr_w-1:0]    r_rptr;

  logic [c_ptr_w-1:0]    w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;

  // The extra pointer MSB distinguishes full from empty when addresses match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]) &&
                   (r_wptr[c_addr_w] != r_rptr[c_addr_w]);
  assign w_count = r_wptr - r_rptr;

  assign w_push = winc & ~w_full;
  assign w_pop  = rinc & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
    end
  end

  // Storage is deliberately left uninitialised; rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[c_addr_w-1:0]] <= wdata;
  end

  assign rdata        = w_empty ? '0 : r_mem[r_rptr[c_addr_w-1:0]];
  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign almost_full  = (w_count >= c_af_level);
  assign almost_empty = (w_count <= c_ae_level);

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_full)  r_overflow  <= 1'b1;
      if (rinc && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// Randomised + directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW   = 8;
  localparam int DEP  = 8;
  localparam int AFT  = 2;
  localparam int AET  = 2;

  logic          rclk_tb;
  logic          rst;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic          wfull;
  logic          rempty;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] q[$];
  bit m_ov = 0;
  bit m_uf = 0;

  sync_fifo #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEP),
    .ALMOST_FULL_THR (AFT),
    .ALMOST_EMPTY_THR(AET)
  ) dut (
    .clk         (rclk_tb),
    .rst         (rst),
    .winc        (winc),
    .wdata       (wdata),
    .rinc        (rinc),
    .rdata       (rdata),
    .wfull       (wfull),
    .rempty      (rempty),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  initial rclk_tb = 1'b0;
  always #5 rclk_tb = ~rclk_tb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".rdata"},        32'(rdata),        (sz > 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".rempty"},       32'(rempty),       32'(sz == 0));
    check({tag, ".wfull"},        32'(wfull),        32'(sz == DEP));
    check({tag, ".almost_full"},  32'(almost_full),  32'((DEP - sz) <= AFT));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AET));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},     32'(overflow),     32'(m_ov));
    check({tag, ".underflow"},    32'(underflow),    32'(m_uf));
`endif
  endtask

  // Called just after a rising edge; applies inputs across the next edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
    int sz;
    bit do_push, do_pop;
    winc  = w;
    wdata = d;
    rinc  = r;
    sz = q.size();
    do_push = w && (sz < DEP);
    do_pop  = r && (sz > 0);
    if (w && sz == DEP) m_ov = 1;
    if (r && sz == 0)   m_uf = 1;
    @(posedge rclk_tb);
    #1;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    winc = 1'b0;
    rinc = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pw[4] = '{80, 20, 50, 90};
    int pr[4] = '{20, 80, 50, 90};
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    #12;
    check_outputs("reset");
    rst = 1'b0;
    @(posedge rclk_tb);
    #1;
    check_outputs("idle");

    // Single push then pop.
    step("push11", 1'b1, 8'h11, 1'b0);
    step("pop11",  1'b0, 8'h00, 1'b1);

    // Fill, overflow attempt, drain.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, DW'(i), 1'b0);
    step("push_full", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1);
    step("pop_empty", 1'b0, 8'h00, 1'b1);

    // Simultaneous push/pop at full and at empty.
    for (int i = 1; i <= 8; i++) step("fill2", 1'b1, DW'(i), 1'b0);
    step("both_full", 1'b1, 8'hAA, 1'b1);
    check("occ_after_both_full", 32'(q.size()), 32'd7);
    while (q.size() > 0) step("drain2", 1'b0, 8'h00, 1'b1);
    step("both_empty", 1'b1, 8'h55, 1'b1);
    step("pop55", 1'b0, 8'h00, 1'b1);

    // Continuous stream through two wraps.
    for (int i = 0; i < 20; i++) step("stream", 1'b1, DW'(i), q.size() > 0);
    while (q.size() > 0) step("stream_drain", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle with data queued.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, DW'(8'hC0 + i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ov = 0;
    m_uf = 0;
    check_outputs("rst_mid");
    #3;
    rst = 1'b0;
    @(posedge rclk_tb);
    #1;
    check_outputs("rst_release");
    step("push77", 1'b1, 8'h77, 1'b0);
    step("pop77",  1'b0, 8'h00, 1'b1);

    // Randomised traffic in phases of differing fill pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 100; c++) begin
        step("rand",
             ($urandom_range(99) < pw[ph]),
             DW'($urandom),
             ($urandom_range(99) < pr[ph]));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
